// File: rtl/select_arbiter.sv
// Round-robin arbiter that grants one requester per beat and registers NUM_SELECT
// words picked from its block. Optional burst lock under SELECT_ARBITER_BURST_EN.

module select_arbiter_lane #(
    parameter int BLOCK_SIZE = 4,
    parameter int WORD_SIZE  = 8,
    parameter int SEL_W      = 2
) (
    input  logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0] i_block,
    input  logic [SEL_W-1:0]                     i_sel,
    output logic [WORD_SIZE-1:0]                 o_word
);
    assign o_word = i_block[i_sel];
endmodule

module select_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BLOCK_SIZE = 4,
    parameter int NUM_SELECT = 3,
    parameter int WORD_SIZE  = 8,
    localparam int SEL_W     = $clog2(BLOCK_SIZE),
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [NUM_REQ-1:0]                               req_valid,
    output logic [NUM_REQ-1:0]                               req_ready,
    input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][WORD_SIZE-1:0] req_block,
    input  logic [NUM_REQ-1:0][NUM_SELECT-1:0][SEL_W-1:0]    req_sel,
`ifdef SELECT_ARBITER_BURST_EN
    input  logic [NUM_REQ-1:0]                               req_last,
`endif
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [NUM_SELECT-1:0][WORD_SIZE-1:0]             out_data,
    output logic [ID_W-1:0]                                  out_id
);

    typedef struct packed {
        logic [NUM_SELECT-1:0][WORD_SIZE-1:0] data;
        logic [ID_W-1:0]                      id;
    } beat_t;

    beat_t                               r_beat;
    logic                                r_valid;
    logic [ID_W-1:0]                     r_last;

    logic                                w_free;
    logic                                w_xfer;
    logic                                w_hi_found, w_lo_found;
    logic [ID_W-1:0]                     w_hi_id, w_lo_id;
    logic                                w_rr_found;
    logic [ID_W-1:0]                     w_rr_id;
    logic                                w_found;
    logic [ID_W-1:0]                     w_gid;
    logic [NUM_REQ-1:0]                  w_req_ready;
    logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0] w_blk;
    logic [NUM_SELECT-1:0][SEL_W-1:0]    w_sel;
    logic [NUM_SELECT-1:0][WORD_SIZE-1:0] w_lane_data;

    assign w_free = !r_valid || out_ready;

    // Two-pass round robin: first valid above last_grant, else first valid overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_id    = '0;
        w_lo_found = 1'b0;
        w_lo_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_id    = ID_W'(i);
            end
            if (req_valid[i] && (ID_W'(i) > r_last) && !w_hi_found) begin
                w_hi_found = 1'b1;
                w_hi_id    = ID_W'(i);
            end
        end
    end

    assign w_rr_found = w_hi_found || w_lo_found;
    assign w_rr_id    = w_hi_found ? w_hi_id : w_lo_id;

`ifdef SELECT_ARBITER_BURST_EN
    logic            r_lock;
    logic [ID_W-1:0] r_lock_id;

    // A locked burst owner is the only candidate; dropping valid just stalls it.
    assign w_found = r_lock ? req_valid[r_lock_id] : w_rr_found;
    assign w_gid   = r_lock ? r_lock_id : w_rr_id;
`else
    assign w_found = w_rr_found;
    assign w_gid   = w_rr_id;
`endif

    assign w_xfer = w_found && w_free && !rst;

    always_comb begin
        w_req_ready = '0;
        if (w_xfer) w_req_ready[w_gid] = 1'b1;
    end

    assign req_ready = w_req_ready;

    assign w_blk = req_block[w_gid];
    assign w_sel = req_sel[w_gid];

    for (genvar k = 0; k < NUM_SELECT; k++) begin : g_lane
        select_arbiter_lane #(
            .BLOCK_SIZE(BLOCK_SIZE),
            .WORD_SIZE (WORD_SIZE),
            .SEL_W     (SEL_W)
        ) u_lane (
            .i_block(w_blk),
            .i_sel  (w_sel[k]),
            .o_word (w_lane_data[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
            r_last  <= ID_W'(NUM_REQ - 1);
        end else if (w_xfer) begin
            r_valid     <= 1'b1;
            r_beat.data <= w_lane_data;
            r_beat.id   <= w_gid;
`ifdef SELECT_ARBITER_BURST_EN
            if (req_last[w_gid]) r_last <= w_gid;
`else
            r_last      <= w_gid;
`endif
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef SELECT_ARBITER_BURST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_xfer) begin
            r_lock    <= !req_last[w_gid];
            r_lock_id <= w_gid;
        end
    end
`endif

    assign out_valid = r_valid;
    assign out_data  = r_beat.data;
    assign out_id    = r_beat.id;

endmodule
